// File: rtl/npu_dispatch_ctrl.sv
// Dispatch controller that hands one decoded NPU instruction at a time to the NPU and retires its result.
// Optional build macro NPU_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module npu_dispatch_ctrl #(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic            is_npu_matrix_mul,
   input  logic            is_npu_conv,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr,
   output logic            stall,
   output logic            npu_cmd_valid,
   input  logic            npu_cmd_ready,
   output logic [1:0]      npu_op,
   output logic [XLEN-1:0] npu_src_a,
   output logic [XLEN-1:0] npu_src_b,
   input  logic            npu_done,
   input  logic [XLEN-1:0] npu_result,
   input  logic            npu_error,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            npu_err,
   output logic            npu_timeout,
   output logic [1:0]      o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_WB    = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_accept;
   logic              w_wait_entry;
   logic [1:0]        r_op;
   logic [XLEN-1:0]   r_src_a;
   logic [XLEN-1:0]   r_src_b;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_rd;
   logic              r_err;

   // Exactly one of the two decode flags must be set for a legal NPU instruction.
   assign w_accept     = issue_valid && (is_npu_matrix_mul ^ is_npu_conv);
   assign w_wait_entry = (r_state == S_ISSUE) && npu_cmd_ready;

`ifdef NPU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] r_cnt;
   logic          w_limit;

   assign w_limit = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_wait_entry) begin
         r_cnt <= '0;
      end else if ((r_state == S_WAIT) && !npu_done && !w_limit) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      stall         = 1'b0;
      npu_cmd_valid = 1'b0;
      wb_valid      = 1'b0;
      npu_err       = 1'b0;
      npu_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               stall  = 1'b1;
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            stall         = 1'b1;
            npu_cmd_valid = 1'b1;
            if (npu_cmd_ready) w_next = S_WAIT;
         end
         S_WAIT: begin
            stall = 1'b1;
            if (npu_done) begin
               w_next = S_WB;
            end
`ifdef NPU_TIMEOUT_EN
            else if (w_limit) begin
               npu_timeout = 1'b1;
               w_next      = S_IDLE;
            end
`endif
         end
         S_WB: begin
            // Writes to x0 are dropped; an errored result never reaches the register file.
            wb_valid = !r_err && (r_rd != 5'd0);
            npu_err  = r_err;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= 2'b00;
         r_src_a  <= '0;
         r_src_b  <= '0;
         r_rd     <= 5'd0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && w_accept) begin
            r_op    <= is_npu_matrix_mul ? 2'b01 : 2'b10;
            r_src_a <= rs1_data;
            r_src_b <= rs2_data;
            r_rd    <= rd_addr;
         end
         if ((r_state == S_WAIT) && npu_done) begin
            r_result <= npu_result;
            r_err    <= npu_error;
         end
      end
   end

   assign npu_op      = r_op;
   assign npu_src_a   = r_src_a;
   assign npu_src_b   = r_src_b;
   assign wb_rd       = r_rd;
   assign wb_data     = r_result;
   assign o_dbg_state = r_state;

endmodule
